// File: rtl/addsub_arb_pkg.sv
// Shared types and constants for the round-robin add/subtract arbiter.
// Imported by addsub_unit and addsub_arbiter.
package addsub_arb_pkg;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_WIDTH = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_unit.sv
// Combinational WIDTH-bit add/subtract built from generate/propagate terms.
// Subtract is A + ~B + 1, so carry = 1 means no borrow.
module addsub_unit
    import addsub_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   cy;

    always_comb begin
        b_eff = (op == OP_ADD) ? b : ~b;
        gen   = a & b_eff;
        prop  = a ^ b_eff;
        cy[0] = (op == OP_SUB);
        // Lookahead recurrence; synthesis flattens it into the adder's carry tree.
        for (int i = 0; i < WIDTH; i++) begin
            cy[i+1] = gen[i] | (prop[i] & cy[i]);
        end
        sum   = prop ^ cy[WIDTH-1:0];
        carry = cy[WIDTH];
        ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one addsub_unit among N_REQ requesters.
// Define ADDSUB_ARB_OVF_EN to add the rsp_ovf port and its overflow register.
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   rsp_carry
`ifdef ADDSUB_ARB_OVF_EN
   ,output logic                   rsp_ovf
`endif
);

    localparam logic [ID_W:0]   N_REQ_W = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ-1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              op_q, op_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;

    logic [N_REQ-1:0]  req_rot;
    logic [N_REQ-1:0]  rot_hi_unused;
    logic              any_req;
    logic [ID_W-1:0]   grant_off;
    logic [ID_W:0]     grant_sum;
    logic [ID_W-1:0]   grant_id;
    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;
    logic              op_sel;

    logic [WIDTH-1:0]  unit_sum;
    logic              unit_carry;
`ifdef ADDSUB_ARB_OVF_EN
    logic              ovf_q, ovf_d;
    logic              unit_ovf;
`else
    logic              ovf_unused;
`endif

    addsub_unit #(.WIDTH(WIDTH)) u_addsub (
        .a     (a_q),
        .b     (b_q),
        .op    (op_q),
        .sum   (unit_sum),
        .carry (unit_carry),
`ifdef ADDSUB_ARB_OVF_EN
        .ovf   (unit_ovf)
`else
        .ovf   (ovf_unused)
`endif
    );

    // Rotate so bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        {rot_hi_unused, req_rot} = {req_valid, req_valid} >> ptr_q;
        any_req   = |req_valid;
        grant_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) grant_off = ID_W'(k);
        end
        grant_sum = {1'b0, ptr_q} + {1'b0, grant_off};
        grant_id  = (grant_sum >= N_REQ_W) ? ID_W'(grant_sum - N_REQ_W) : grant_sum[ID_W-1:0];

        a_sel  = '0;
        b_sel  = '0;
        op_sel = OP_ADD;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                a_sel  = req_a[k*WIDTH +: WIDTH];
                b_sel  = req_b[k*WIDTH +: WIDTH];
                op_sel = req_op[k];
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
`ifdef ADDSUB_ARB_OVF_EN
        ovf_d     = ovf_q;
`endif
        req_ready = '0;

        case (state_q)
            IDLE: begin
                // Gated by rst_n so the strobe drops the moment reset asserts.
                if (any_req && rst_n) begin
                    for (int k = 0; k < N_REQ; k++) begin
                        req_ready[k] = (grant_id == ID_W'(k));
                    end
                end
                if (any_req) begin
                    id_d    = grant_id;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    op_d    = op_sel;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                sum_d   = unit_sum;
                carry_d = unit_carry;
`ifdef ADDSUB_ARB_OVF_EN
                ovf_d   = unit_ovf;
`endif
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    ptr_d   = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            sum_q   <= '0;
            carry_q <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
`ifdef ADDSUB_ARB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_carry = carry_q;
`ifdef ADDSUB_ARB_OVF_EN
    assign rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed steps plus randomized traffic
// compared against a plain-arithmetic reference model (ADDSUB_ARB_OVF_EN aware).
module tb_addsub_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N-1:0]     req_op = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_sum;
    logic             rsp_carry;
`ifdef ADDSUB_ARB_OVF_EN
    logic             rsp_ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    bit           pend[N];
    logic [W-1:0] pa[N];
    logic [W-1:0] pb[N];
    logic         pop[N];
    int           ptr_m = 0;
    int           last_wait = 0;
    logic [W-1:0] obs_sum;
    logic         obs_carry;

    addsub_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry)
`ifdef ADDSUB_ARB_OVF_EN
       ,.rsp_ovf   (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {carry, sum} from unsigned integer arithmetic.
    function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        int ua;
        int ub;
        int t;
        logic [W-1:0] s;
        logic c;
        ua = int'(a);
        ub = int'(b);
        if (op == 1'b0) begin
            t = ua + ub;
            c = (t > 65535);
        end else begin
            t = ua - ub;
            c = (ua >= ub);
        end
        s = W'(t);
        return {c, s};
    endfunction

    // Reference: signed overflow means the true signed result leaves the 16-bit range.
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        int sa;
        int sb;
        int r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = (op == 1'b0) ? sa + sb : sa - sb;
        return (r > 32767) || (r < -32768);
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = pend[i];
            req_a[i*W +: W]   = pa[i];
            req_b[i*W +: W]   = pb[i];
            req_op[i]         = pop[i];
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
        pop[i]  = op;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
    endtask

    // One full transaction; the winner is predicted from the pending set and ptr_m.
    task automatic run_txn(input int rsp_delay, input bit hold_ready);
        int g;
        int waited;
        logic [W:0] exp_cs;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && pend[(ptr_m + k) % N]) g = (ptr_m + k) % N;
        end
        if (g < 0) return;
        rsp_ready = hold_ready;
        drive_inputs();
        #1;
        waited = 0;
        while (req_ready == '0 && waited < 20) begin
            @(posedge clk); #2;
            waited++;
        end
        last_wait = waited;
        check("grant_seen", 32'(req_ready != '0), 32'd1);
        if (req_ready == '0) return;
        check("req_ready_onehot", 32'(req_ready), 32'(1 << g));
        exp_cs = ref_result(pa[g], pb[g], pop[g]);

        @(posedge clk); #2;
        pend[g] = 1'b0;
        drive_inputs();
        #1;
        check("exec_req_ready", 32'(req_ready), 32'd0);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);

        @(posedge clk); #2;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(g));
        check("rsp_sum", 32'(rsp_sum), 32'(exp_cs[W-1:0]));
        check("rsp_carry", 32'(rsp_carry), 32'(exp_cs[W]));
`ifdef ADDSUB_ARB_OVF_EN
        check("rsp_ovf", 32'(rsp_ovf), 32'(ref_ovf(pa[g], pb[g], pop[g])));
`endif
        obs_sum   = rsp_sum;
        obs_carry = rsp_carry;

        if (!hold_ready) begin
            for (int d = 0; d < rsp_delay; d++) begin
                @(posedge clk); #2;
                check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
                check("bp_rsp_sum", 32'(rsp_sum), 32'(exp_cs[W-1:0]));
                check("bp_rsp_id", 32'(rsp_id), 32'(g));
                check("bp_req_ready", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
        end

        @(posedge clk); #2;
        check("after_hs_valid", 32'(rsp_valid), 32'd0);
        ptr_m = (g + 1) % N;
        if (!hold_ready) rsp_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 16'hFFFF;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            default: return W'($urandom());
        endcase
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1;
            pa[i]   = 16'h1111;
            pb[i]   = 16'h2222;
            pop[i]  = 1'b0;
        end
        drive_inputs();
        #12;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_sum", 32'(rsp_sum), 32'd0);
        check("reset_rsp_carry", 32'(rsp_carry), 32'd0);
`ifdef ADDSUB_ARB_OVF_EN
        check("reset_rsp_ovf", 32'(rsp_ovf), 32'd0);
`endif
        clear_reqs();
        drive_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single add on requester 0.
        set_req(0, 16'h1234, 16'h0F0F, 1'b0);
        run_txn(0, 1'b0);
        check("add_literal_sum", 32'(obs_sum), 32'h2143);
        check("add_literal_carry", 32'(obs_carry), 32'd0);

        // Subtract with and without borrow on requester 2.
        set_req(2, 16'h0003, 16'h0005, 1'b1);
        run_txn(0, 1'b0);
        check("sub_borrow_sum", 32'(obs_sum), 32'hFFFE);
        check("sub_borrow_carry", 32'(obs_carry), 32'd0);
        set_req(2, 16'h0005, 16'h0003, 1'b1);
        run_txn(0, 1'b0);
        check("sub_noborrow_sum", 32'(obs_sum), 32'h0002);
        check("sub_noborrow_carry", 32'(obs_carry), 32'd1);

        // Signed-overflow corners.
        set_req(1, 16'h7FFF, 16'h0001, 1'b0);
        run_txn(0, 1'b0);
        check("ovf_add_sum", 32'(obs_sum), 32'h8000);
        set_req(3, 16'h8000, 16'h0001, 1'b1);
        run_txn(0, 1'b0);
        check("ovf_sub_sum", 32'(obs_sum), 32'h7FFF);
        check("ovf_sub_carry", 32'(obs_carry), 32'd1);

        // Backpressure for 10 cycles with others waiting, then the next in order.
        set_req(0, 16'hABCD, 16'h1234, 1'b0);
        set_req(1, 16'h0100, 16'h0200, 1'b1);
        set_req(2, 16'hFFFF, 16'h0001, 1'b0);
        run_txn(10, 1'b0);
        run_txn(0, 1'b0);

        // All requesters continuously valid with rsp_ready held: one result every 3 cycles.
        for (int i = 0; i < N; i++) begin
            if (!pend[i]) set_req(i, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        end
        for (int t = 0; t < 8; t++) begin
            int g_prev;
            g_prev = ptr_m;
            run_txn(0, 1'b1);
            if (t > 0) check("rr_back_to_back", 32'(last_wait), 32'd0);
            g_prev = (ptr_m + N - 1) % N;
            set_req(g_prev, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        end
        rsp_ready = 1'b0;

        // Randomized traffic with random response delays.
        for (int t = 0; t < 30; t++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
                any |= pend[i];
            end
            if (!any) set_req(int'($urandom_range(0, N - 1)), rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
            run_txn(int'($urandom_range(0, 3)), 1'b0);
        end

        // Drain remaining requests so nothing is granted behind the bench's back.
        for (int t = 0; t < N; t++) run_txn(0, 1'b0);

        // Reset asserted during EXEC: outputs clear at once, no response afterwards.
        clear_reqs();
        set_req(3, 16'hAAAA, 16'h1111, 1'b0);
        drive_inputs();
        #1;
        begin
            int waited;
            waited = 0;
            while (req_ready == '0 && waited < 20) begin
                @(posedge clk); #2;
                waited++;
            end
            check("rst_grant_seen", 32'(req_ready), 32'b1000);
        end
        @(posedge clk); #2;
        clear_reqs();
        set_req(1, 16'h0001, 16'h0002, 1'b0);
        set_req(3, 16'h0010, 16'h0020, 1'b0);
        drive_inputs();
        rst_n = 1'b0;
        #1;
        check("midop_req_ready", 32'(req_ready), 32'd0);
        check("midop_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midop_rsp_id", 32'(rsp_id), 32'd0);
        check("midop_rsp_sum", 32'(rsp_sum), 32'd0);
        check("midop_rsp_carry", 32'(rsp_carry), 32'd0);
        @(posedge clk); #2;
        check("midop_hold_valid", 32'(rsp_valid), 32'd0);
        ptr_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(0, 1'b0);
        run_txn(0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
